// File: rtl/path_tracer.sv
// path_tracer: walks a snapshot of the predecessor table back from end_node
// to st_node, stacks the nodes, then streams them forward (st_node first)
// over a valid/ready interface.
module path_tracer #(
  parameter int NODES   = 26,
  parameter int NODE_W  = 5,
  parameter int MAX_LEN = 26
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           found,
  input  logic [NODE_W-1:0]              st_node,
  input  logic [NODE_W-1:0]              end_node,
  input  logic [NODES*NODE_W-1:0]        prev_flat,
  output logic [NODE_W-1:0]              node_out,
  output logic                           node_valid,
  input  logic                           node_ready,
  output logic                           node_last,
  output logic [$clog2(MAX_LEN+1)-1:0]   path_len,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int SP_W = $clog2(MAX_LEN+1);
  localparam logic [NODE_W:0]   NODES_C = (NODE_W+1)'(NODES);
  localparam logic [SP_W-1:0]   MAX_C   = SP_W'(MAX_LEN);
  localparam logic [SP_W-1:0]   ONE_SP  = SP_W'(1);

  typedef enum logic [1:0] {IDLE, WALK, EMIT, ERR} state_t;

  state_t            state, state_nxt;
  logic [NODE_W-1:0] prev_mem [NODES];
  logic [NODE_W-1:0] stack    [MAX_LEN];
  logic [NODE_W-1:0] cur;
  logic [NODE_W-1:0] st_q;
  logic [NODE_W-1:0] prev_cur;
  logic [SP_W-1:0]   sp;
  logic              start_ok;
  logic              at_start;
  logic              prev_bad;
  logic              overflow;
  logic              beat_take;

  // Request qualification and walk-step decisions
  always_comb begin
    start_ok  = found && ({1'b0, st_node} < NODES_C) && ({1'b0, end_node} < NODES_C);
    prev_cur  = prev_mem[cur];
    at_start  = (cur == st_q);
    prev_bad  = ({1'b0, prev_cur} >= NODES_C);
    overflow  = ((sp + ONE_SP) == MAX_C);
    beat_take = (state == EMIT) && node_ready;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = start_ok ? WALK : ERR;
      WALK: begin
        if (at_start)      state_nxt = EMIT;
        else if (prev_bad) state_nxt = ERR;
        else if (overflow) state_nxt = ERR;
      end
      EMIT: if (node_ready && sp == ONE_SP) state_nxt = IDLE;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; node_out is forced to zero outside EMIT
  always_comb begin
    busy       = (state != IDLE);
    node_valid = (state == EMIT);
    node_last  = (state == EMIT) && (sp == ONE_SP);
    err        = (state == ERR);
    node_out   = (state == EMIT) ? stack[sp - ONE_SP] : '0;
  end

  // Walk cursor, stack pointer, path length and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      st_q     <= '0;
      sp       <= '0;
      path_len <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            path_len <= '0;
            sp       <= '0;
            if (start_ok) begin
              cur  <= end_node;
              st_q <= st_node;
            end
          end
        end
        WALK: begin
          sp <= sp + ONE_SP;
          if (at_start) path_len <= sp + ONE_SP;
          else          cur      <= prev_cur;
        end
        EMIT: begin
          if (beat_take) begin
            sp <= sp - ONE_SP;
            if (sp == ONE_SP) done <= 1'b1;
          end
        end
        ERR: begin
          sp       <= '0;
          path_len <= '0;
        end
        default: sp <= '0;
      endcase
    end
  end

  // Table snapshot on an accepted start; the search may overwrite prev_flat afterwards
  always_ff @(posedge clk) begin
    if (state == IDLE && start && start_ok)
      for (int unsigned i = 0; i < NODES; i++)
        prev_mem[i] <= prev_flat[NODE_W*i +: NODE_W];
  end

  // Stack write; emptiness is tracked by sp alone
  always_ff @(posedge clk) begin
    if (state == WALK) stack[sp] <= cur;
  end

endmodule

// File: tb/tb_path_tracer.sv
// Directed bench for path_tracer with a beat scoreboard.
module tb_path_tracer;
  localparam int NODES   = 26;
  localparam int NODE_W  = 5;
  localparam int MAX_LEN = 26;
  localparam int LW      = $clog2(MAX_LEN+1);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    found = 1'b0;
  logic [NODE_W-1:0]       st_node = '0;
  logic [NODE_W-1:0]       end_node = '0;
  logic [NODES*NODE_W-1:0] prev_flat = '1;
  logic [NODE_W-1:0]       node_out;
  logic                    node_valid;
  logic                    node_ready = 1'b0;
  logic                    node_last;
  logic [LW-1:0]           path_len;
  logic                    busy;
  logic                    done;
  logic                    err;

  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic              last;
  } beat_t;

  beat_t sb[$];
  int errors = 0;
  int checks = 0;

  path_tracer #(.NODES(NODES), .NODE_W(NODE_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .found(found),
    .st_node(st_node), .end_node(end_node), .prev_flat(prev_flat),
    .node_out(node_out), .node_valid(node_valid), .node_ready(node_ready),
    .node_last(node_last), .path_len(path_len), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_prev(input int i, input int v);
    prev_flat[NODE_W*i +: NODE_W] = NODE_W'(v);
  endtask

  task automatic push_beat(input int n, input bit last);
    beat_t b;
    b.node = NODE_W'(n);
    b.last = last;
    sb.push_back(b);
  endtask

  // Called at a negedge; leaves at the next negedge with start low again
  task automatic do_start(input int s, input int e, input bit f);
    st_node  = NODE_W'(s);
    end_node = NODE_W'(e);
    found    = f;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating; mode 2: ready high, start pulsed mid-stream
  task automatic run_path(input string tag, input int exp_walk, input int exp_len, input int mode);
    int walk = 0;
    int guard = 0;
    int k = 0;
    beat_t b;
    while (!node_valid && !err && guard < 100) begin
      walk++;
      guard++;
      @(negedge clk);
    end
    chk({tag, "_walk_cycles"}, walk, exp_walk);
    chk({tag, "_path_len"}, 32'(path_len), exp_len);
    while (sb.size() > 0 && guard < 200) begin
      b = sb[0];
      chk({tag, "_valid_held"}, 32'(node_valid), 1);
      chk({tag, "_node"}, 32'(node_out), 32'(b.node));
      chk({tag, "_last"}, 32'(node_last), 32'(b.last));
      if (mode == 1) node_ready = (k % 4 == 0) || (k % 4 == 3);
      else           node_ready = 1'b1;
      if (mode == 2) begin
        start    = (k == 1);
        found    = 1'b1;
        st_node  = NODE_W'(12);
        end_node = NODE_W'(12);
      end
      if (node_ready) void'(sb.pop_front());
      k++;
      guard++;
      @(negedge clk);
    end
    start = 1'b0;
    found = 1'b0;
    chk({tag, "_no_timeout"}, guard < 200, 1);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_valid_after"}, 32'(node_valid), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_len_hold"}, 32'(path_len), exp_len);
  endtask

  task automatic run_err(input string tag, input int exp_walk);
    int walk = 0;
    int guard = 0;
    int seen_valid = 0;
    while (!err && guard < 100) begin
      if (node_valid) seen_valid++;
      if (busy) walk++;
      guard++;
      @(negedge clk);
    end
    chk({tag, "_err"}, 32'(err), 1);
    chk({tag, "_walk_cycles"}, walk, exp_walk);
    chk({tag, "_no_beats"}, seen_valid, 0);
    chk({tag, "_path_len"}, 32'(path_len), 0);
    chk({tag, "_no_done"}, 32'(done), 0);
    @(negedge clk);
    chk({tag, "_err_pulse"}, 32'(err), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int guard;

    // reset
    #12;
    chk("rst_valid", 32'(node_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out", 32'(node_out), 0);
    chk("rst_len", 32'(path_len), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_done", 32'(done), 0);
    chk("idle_err", 32'(err), 0);

    // 1: 7 -> 3 -> 0, ready high
    set_prev(7, 3);
    set_prev(3, 0);
    push_beat(0, 0); push_beat(3, 0); push_beat(7, 1);
    do_start(0, 7, 1);
    run_path("t1", 3, 3, 0);

    // 2: same path, ready toggling; table clobbered after start to prove the snapshot
    push_beat(0, 0); push_beat(3, 0); push_beat(7, 1);
    do_start(0, 7, 1);
    set_prev(7, 31);
    set_prev(3, 31);
    run_path("t2", 3, 3, 1);

    // 3: single-node path
    push_beat(12, 1);
    do_start(12, 12, 1);
    run_path("t3", 1, 1, 0);

    // 4: broken chain
    set_prev(5, 31);
    do_start(0, 5, 1);
    run_err("t4", 1);

    // 5: cycle in table
    set_prev(4, 9);
    set_prev(9, 4);
    do_start(0, 4, 1);
    run_err("t5", MAX_LEN);

    // 6a: start without found, and with an out-of-range id
    do_start(0, 7, 0);
    run_err("t6_nofound", 0);
    do_start(0, 26, 1);
    run_err("t6_badid", 0);

    // 6b: start pulse during EMIT is ignored
    set_prev(7, 3);
    set_prev(3, 0);
    push_beat(0, 0); push_beat(3, 0); push_beat(7, 1);
    do_start(0, 7, 1);
    run_path("t6_ign", 3, 3, 2);
    repeat (3) @(negedge clk);
    chk("t6_ign_stay_idle", 32'(busy), 0);

    // 6c: reset asserted mid-EMIT
    node_ready = 1'b0;
    do_start(0, 7, 1);
    guard = 0;
    while (!node_valid && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    chk("t6_rst_reached_emit", 32'(node_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(node_valid), 0);
    chk("t6_rst_out", 32'(node_out), 0);
    chk("t6_rst_last", 32'(node_last), 0);
    chk("t6_rst_len", 32'(path_len), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    node_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_post_rst_done", 32'(done), 0);
      chk("t6_post_rst_valid", 32'(node_valid), 0);
    end

    // recovery after reset: a fresh trace still works
    push_beat(0, 0); push_beat(3, 0); push_beat(7, 1);
    do_start(0, 7, 1);
    run_path("t7", 3, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
